// File: rtl/unidade_controle_exp6.sv
// Memory-game controller (Moore FSM).
// Sequences the datapath through 16 rounds of growing length. The game ends
// with a success, a wrong play, or a timeout. The state code is exported on
// db_estado for the debug displays.
module unidade_controle_exp6 (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fimE,
  input  logic       fimRod,
  input  logic       fimT,
  input  logic       igual,
  input  logic       enderecoIgualRodada,
  input  logic       jogada_feita,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraRod,
  output logic       contaRod,
  output logic       zeraT,
  output logic       contaT,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIO_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTO     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } estado_t;

  estado_t estado;
  estado_t proximo;

  // fimE is kept on the port list for pin compatibility but does not steer
  // the sequence; round completion is detected via enderecoIgualRodada.
  logic unused_fim_e;
  assign unused_fim_e = fimE;

  // Next-state logic
  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:        proximo = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     proximo = INICIO_RODADA;
      INICIO_RODADA:  proximo = ESPERA_JOGADA;
      // A play arriving in the same cycle as the timer expiry takes priority.
      ESPERA_JOGADA: begin
        if (jogada_feita)  proximo = REGISTRA;
        else if (fimT)     proximo = FIM_TIMEOUT;
        else               proximo = ESPERA_JOGADA;
      end
      REGISTRA:       proximo = COMPARACAO;
      COMPARACAO: begin
        if (!igual)                    proximo = FIM_ERRO;
        else if (!enderecoIgualRodada) proximo = PROXIMA_JOGADA;
        else if (fimRod)               proximo = FIM_ACERTO;
        else                           proximo = PROXIMA_RODADA;
      end
      PROXIMA_JOGADA: proximo = ESPERA_JOGADA;
      PROXIMA_RODADA: proximo = INICIO_RODADA;
      FIM_ACERTO:     proximo = iniciar ? PREPARACAO : FIM_ACERTO;
      FIM_ERRO:       proximo = iniciar ? PREPARACAO : FIM_ERRO;
      FIM_TIMEOUT:    proximo = iniciar ? PREPARACAO : FIM_TIMEOUT;
      default:        proximo = INICIAL;
    endcase
  end

  // State register with outputs registered from the next-state decode, so
  // each output is a pure function of the state it accompanies.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= INICIAL;
      zeraE     <= 1'b0;
      contaE    <= 1'b0;
      zeraRod   <= 1'b0;
      contaRod  <= 1'b0;
      zeraT     <= 1'b0;
      contaT    <= 1'b0;
      zeraR     <= 1'b0;
      registraR <= 1'b0;
      pronto    <= 1'b0;
      acertou   <= 1'b0;
      errou     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      estado    <= proximo;
      zeraE     <= (proximo == PREPARACAO) || (proximo == INICIO_RODADA);
      contaE    <= (proximo == PROXIMA_JOGADA);
      zeraRod   <= (proximo == PREPARACAO);
      contaRod  <= (proximo == PROXIMA_RODADA);
      zeraT     <= (proximo == PREPARACAO) || (proximo == INICIO_RODADA) ||
                   (proximo == REGISTRA);
      contaT    <= (proximo == ESPERA_JOGADA);
      zeraR     <= (proximo == PREPARACAO);
      registraR <= (proximo == REGISTRA);
      pronto    <= (proximo == FIM_ACERTO) || (proximo == FIM_ERRO) ||
                   (proximo == FIM_TIMEOUT);
      acertou   <= (proximo == FIM_ACERTO);
      errou     <= (proximo == FIM_ERRO);
      timeout   <= (proximo == FIM_TIMEOUT);
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_exp6.sv
// Directed bench for the memory-game controller with an expected-state queue.
module tb_unidade_controle_exp6;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       fimE = 1'b0;
  logic       fimRod = 1'b0;
  logic       fimT = 1'b0;
  logic       igual = 1'b0;
  logic       enderecoIgualRodada = 1'b0;
  logic       jogada_feita = 1'b0;
  logic       zeraE, contaE, zeraRod, contaRod, zeraT, contaT;
  logic       zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [3:0]  exp_q[$];

  unidade_controle_exp6 dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .fimE(fimE),
    .fimRod(fimRod), .fimT(fimT), .igual(igual),
    .enderecoIgualRodada(enderecoIgualRodada), .jogada_feita(jogada_feita),
    .zeraE(zeraE), .contaE(contaE), .zeraRod(zeraRod), .contaRod(contaRod),
    .zeraT(zeraT), .contaT(contaT), .zeraR(zeraR), .registraR(registraR),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Output vector order: zeraE contaE zeraRod contaRod zeraT contaT
  //                      zeraR registraR pronto acertou errou timeout
  function automatic logic [11:0] saidas_esperadas(input logic [3:0] s);
    case (s)
      4'h1:    return 12'b1010_1010_0000;
      4'h2:    return 12'b1000_1000_0000;
      4'h3:    return 12'b0000_0100_0000;
      4'h4:    return 12'b0000_1001_0000;
      4'h6:    return 12'b0100_0000_0000;
      4'h7:    return 12'b0001_0000_0000;
      4'hA:    return 12'b0000_0000_1100;
      4'hE:    return 12'b0000_0000_1010;
      4'hD:    return 12'b0000_0000_1001;
      default: return 12'b0000_0000_0000;
    endcase
  endfunction

  function automatic logic [11:0] saidas_obs();
    return {zeraE, contaE, zeraRod, contaRod, zeraT, contaT,
            zeraR, registraR, pronto, acertou, errou, timeout};
  endfunction

  task automatic verifica(input string tag, input logic [3:0] exp_s);
    logic [11:0] exp_o;
    logic [11:0] obs_o;
    exp_o = saidas_esperadas(exp_s);
    obs_o = saidas_obs();
    n_checks++;
    assert (db_estado === exp_s) else begin
      n_fail++;
      $error("FAIL %s db_estado: observed %h expected %h", tag, db_estado, exp_s);
    end
    n_checks++;
    assert (obs_o === exp_o) else begin
      n_fail++;
      $error("FAIL %s outputs: observed %b expected %b", tag, obs_o, exp_o);
    end
  endtask

  // Push the expected state for the coming edge, then pop and compare after it.
  task automatic passo(input string tag, input logic [3:0] exp_s);
    logic [3:0] e;
    exp_q.push_back(exp_s);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    verifica(tag, e);
  endtask

  initial begin
    // Reset held low
    #2;
    verifica("reset_inicial", 4'h0);
    @(posedge clock); #1;
    verifica("reset_mantido", 4'h0);
    reset = 1'b1;

    passo("ocioso", 4'h0);
    iniciar = 1'b1;
    passo("preparacao", 4'h1);
    iniciar = 1'b0;
    passo("inicio_rodada", 4'h2);
    passo("espera", 4'h3);
    passo("espera_mantida", 4'h3);
    iniciar = 1'b1;
    passo("iniciar_ignorado", 4'h3);
    iniciar = 1'b0;

    // Round 0 completes
    jogada_feita = 1'b1; igual = 1'b1; enderecoIgualRodada = 1'b1; fimRod = 1'b0;
    passo("r0_registra", 4'h4);
    jogada_feita = 1'b0;
    passo("r0_comparacao", 4'h5);
    passo("r0_proxima_rodada", 4'h7);
    passo("r0_inicio_rodada", 4'h2);
    passo("r0_espera", 4'h3);

    // Intermediate play of a round
    jogada_feita = 1'b1; enderecoIgualRodada = 1'b0;
    passo("r1_registra", 4'h4);
    jogada_feita = 1'b0;
    passo("r1_comparacao", 4'h5);
    passo("r1_proxima_jogada", 4'h6);
    passo("r1_espera", 4'h3);

    // Wrong play; igual=0 wins even with enderecoIgualRodada=1 and fimRod=1
    jogada_feita = 1'b1; enderecoIgualRodada = 1'b1; fimRod = 1'b1;
    passo("erro_registra", 4'h4);
    jogada_feita = 1'b0; igual = 1'b0;
    passo("erro_comparacao", 4'h5);
    passo("fim_erro", 4'hE);
    for (int i = 0; i < 10; i++) passo("fim_erro_mantido", 4'hE);
    iniciar = 1'b1;
    passo("erro_reinicio", 4'h1);
    iniciar = 1'b0; igual = 1'b1; fimRod = 1'b0;
    passo("erro_inicio_rodada", 4'h2);
    passo("erro_espera", 4'h3);

    // Timeout
    fimT = 1'b1;
    passo("fim_timeout", 4'hD);
    fimT = 1'b0;
    passo("fim_timeout_mantido", 4'hD);
    iniciar = 1'b1;
    passo("timeout_reinicio", 4'h1);
    iniciar = 1'b0;
    passo("timeout_inicio_rodada", 4'h2);
    passo("timeout_espera", 4'h3);

    // Same-cycle play and timer expiry: play wins, then final success
    jogada_feita = 1'b1; fimT = 1'b1;
    passo("jogada_vence_timer", 4'h4);
    jogada_feita = 1'b0; fimT = 1'b0;
    igual = 1'b1; enderecoIgualRodada = 1'b1; fimRod = 1'b1;
    passo("final_comparacao", 4'h5);
    passo("fim_acerto", 4'hA);
    passo("fim_acerto_mantido", 4'hA);
    iniciar = 1'b1;
    passo("acerto_reinicio", 4'h1);
    iniciar = 1'b0; fimRod = 1'b0;
    passo("acerto_inicio_rodada", 4'h2);
    passo("acerto_espera", 4'h3);

    // Asynchronous reset in the middle of a play wait
    #2;
    reset = 1'b0;
    #1;
    verifica("reset_assincrono", 4'h0);
    @(posedge clock); #1;
    verifica("reset_baixo_1", 4'h0);
    iniciar = 1'b1;
    @(posedge clock); #1;
    verifica("reset_baixo_2", 4'h0);
    iniciar = 1'b0;
    reset = 1'b1;
    passo("pos_reset", 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
